seg7_scan: RTL and testbench

Time-multiplexed scan controller for an 8-digit common-anode 7-segment display. Holds a frame of display content (32-bit hex value, per-digit dot mask, display mode), steps through digits at a programmable rate, and drives the per-digit control inputs (`din`, `none`, `num`, `dot`, `hi_1`, `hi_2`, `lo_1`, `lo_2`) of the single downstream SEG7 decoder. It also generates the matching active-low digit-enable lines, delayed to line up with SEG7's registered segment output. New content is accepted at any time and applied only at a frame boundary, so the display never shows a torn frame.

---
 rtl/seg7_scan_if.sv | 32 +++
 rtl/seg7_scan.sv | 165 ++++++++++++++++
 tb/tb_seg7_scan.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan bus: frame content in, SEG7 selectors and digit enables out.
// master drives content; slave is the scan controller.
interface seg7_scan_if;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dots;
  logic [1:0]  mode;
  logic [3:0]  din;
  logic        num;
  logic        none;
  logic        dot;
  logic        hi_1;
  logic        hi_2;
  logic        lo_1;
  logic        lo_2;
  logic [7:0]  an_n;
  logic        frame;

  modport master (
    output load, value, dots, mode,
    input  din, num, none, dot,
    input  hi_1, hi_2, lo_1, lo_2,
    input  an_n, frame
  );

  modport slave (
    input  load, value, dots, mode,
    output din, num, none, dot,
    output hi_1, hi_2, lo_1, lo_2,
    output an_n, frame
  );
endinterface

// File: rtl/seg7_scan.sv
// 8-digit 7-seg scan controller with frame-boundary content swap.
// Define SEG7_SCAN_LZB_EN for leading-zero blanking in number mode.
module seg7_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 1024
) (
  input logic       clk,
  input logic       reset,
  seg7_scan_if.slave bus
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [2:0]    idx_d1;
  logic          v1;
  logic          tick;
  logic          wrap;

  logic [31:0]   pnd_value;
  logic [7:0]    pnd_dots;
  logic [1:0]    pnd_mode;
  logic          pend_v;

  logic [31:0]   act_value;
  logic [7:0]    act_dots;
  logic [1:0]    act_mode;

  logic [7:0]    blank;
  logic [3:0]    nib;
  logic [7:0]    an_nxt;

  logic [3:0]    d_din;
  logic          d_num;
  logic          d_none;
  logic          d_hi1;
  logic          d_hi2;
  logic          d_lo1;
  logic          d_lo2;

  assign tick = (pre == PW'(DIV - 1));
  assign wrap = tick && (idx == 3'(DIGITS - 1));
  assign nib  = act_value[{idx, 2'b00} +: 4];

`ifdef SEG7_SCAN_LZB_EN
  // blank[k]: nibble k and every nibble above it are zero
  always_comb begin
    logic z;
    z     = 1'b1;
    blank = '0;
    for (int k = 7; k >= 1; k--) begin
      z        = z & (act_value[4*k +: 4] == 4'd0);
      blank[k] = z;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    d_din  = 4'd0;
    d_num  = 1'b0;
    d_none = 1'b0;
    d_hi1  = 1'b0;
    d_hi2  = 1'b0;
    d_lo1  = 1'b0;
    d_lo2  = 1'b0;
    unique case (act_mode)
      2'd0: begin
        if (blank[idx]) begin
          d_none = 1'b1;
        end else begin
          d_num = 1'b1;
          d_din = nib;
        end
      end
      2'd1: begin
        if (idx == 3'd1)      d_hi1  = 1'b1;
        else if (idx == 3'd0) d_hi2  = 1'b1;
        else                  d_none = 1'b1;
      end
      2'd2: begin
        if (idx == 3'd1)      d_lo1  = 1'b1;
        else if (idx == 3'd0) d_lo2  = 1'b1;
        else                  d_none = 1'b1;
      end
      default: d_none = 1'b1;
    endcase
  end

  always_comb begin
    an_nxt = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_d1 == 3'(k)) an_nxt[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre       <= '0;
      idx       <= '0;
      idx_d1    <= '0;
      v1        <= 1'b0;
      pend_v    <= 1'b0;
      pnd_value <= '0;
      pnd_dots  <= '0;
      pnd_mode  <= 2'd3;
      act_value <= '0;
      act_dots  <= '0;
      act_mode  <= 2'd3;
      bus.din   <= 4'd0;
      bus.num   <= 1'b0;
      bus.none  <= 1'b1;
      bus.dot   <= 1'b0;
      bus.hi_1  <= 1'b0;
      bus.hi_2  <= 1'b0;
      bus.lo_1  <= 1'b0;
      bus.lo_2  <= 1'b0;
      bus.an_n  <= 8'hFF;
      bus.frame <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) idx <= wrap ? 3'd0 : idx + 3'd1;

      bus.frame <= 1'b0;
      if (wrap) begin
        // a load landing on the wrap skips pending entirely
        if (bus.load) begin
          act_value <= bus.value;
          act_dots  <= bus.dots;
          act_mode  <= bus.mode;
          pend_v    <= 1'b0;
          bus.frame <= 1'b1;
        end else if (pend_v) begin
          act_value <= pnd_value;
          act_dots  <= pnd_dots;
          act_mode  <= pnd_mode;
          pend_v    <= 1'b0;
          bus.frame <= 1'b1;
        end
      end else if (bus.load) begin
        pnd_value <= bus.value;
        pnd_dots  <= bus.dots;
        pnd_mode  <= bus.mode;
        pend_v    <= 1'b1;
      end

      bus.din  <= d_din;
      bus.num  <= d_num;
      bus.none <= d_none;
      bus.dot  <= act_dots[idx];
      bus.hi_1 <= d_hi1;
      bus.hi_2 <= d_hi2;
      bus.lo_1 <= d_lo1;
      bus.lo_2 <= d_lo2;

      // second stage matches the SEG7 output register
      idx_d1   <= idx;
      v1       <= 1'b1;
      bus.an_n <= v1 ? an_nxt : 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan, DIGITS=8, DIV=4.
// Vector table for decode plus sequences for reset/load/wrap corners.
module tb_seg7_scan;

`ifdef SEG7_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   nframes;

  seg7_scan_if bus ();

  seg7_scan #(.DIGITS(8), .DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial nframes = 0;
  always @(posedge clk) if (bus.frame === 1'b1) nframes++;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dots;
    logic [1:0]  mode;
    int          digit;
    logic [10:0] exp;
  } vec_t;

  vec_t vt[$];

  // {din, num, none, hi_1, hi_2, lo_1, lo_2, dot}
  function automatic logic [10:0] obs();
    return {bus.din, bus.num, bus.none, bus.hi_1,
            bus.hi_2, bus.lo_1, bus.lo_2, bus.dot};
  endfunction

  function automatic logic [10:0] xn(logic [3:0] d, logic dt);
    return {d, 2'b10, 4'b0000, dt};
  endfunction
  function automatic logic [10:0] xb(logic dt);
    return {4'h0, 2'b01, 4'b0000, dt};
  endfunction
  function automatic logic [10:0] xs(logic [3:0] s, logic dt);
    return {4'h0, 2'b00, s, dt};
  endfunction
  function automatic logic [10:0] lz(logic dt);
    return LZB ? xb(dt) : xn(4'h0, dt);
  endfunction

  function automatic vec_t mk(logic [31:0] v, logic [7:0] d,
                              logic [1:0] m, int k, logic [10:0] e);
    vec_t r;
    r.value = v; r.dots = d; r.mode = m; r.digit = k; r.exp = e;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(logic [31:0] v, logic [7:0] d, logic [1:0] m);
    @(negedge clk);
    bus.load = 1'b1; bus.value = v; bus.dots = d; bus.mode = m;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_frame(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.frame === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // stop on the first cycle a digit becomes enabled
  task automatic wait_digit(int k, string name);
    logic [7:0] tgt;
    bit ok;
    tgt = ~(8'b1 << k);
    ok  = 1'b0;
    for (int i = 0; i < 100 && bus.an_n === tgt; i++) step();
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.an_n === tgt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(name, 32'(bus.an_n), 32'(tgt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   n0;
    int   bad;
    logic [7:0] ea;
    vec_t p;

    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dots = '0; bus.mode = 2'd0;

    vt.push_back(mk(32'h89AB_CDEF, 8'h01, 2'd0, 0, xn(4'hF, 1'b1)));
    vt.push_back(mk(32'h89AB_CDEF, 8'h01, 2'd0, 1, xn(4'hE, 1'b0)));
    vt.push_back(mk(32'h89AB_CDEF, 8'h01, 2'd0, 5, xn(4'hA, 1'b0)));
    vt.push_back(mk(32'h89AB_CDEF, 8'h01, 2'd0, 7, xn(4'h8, 1'b0)));
    vt.push_back(mk(32'h0, 8'h82, 2'd1, 0, xs(4'b0100, 1'b0)));
    vt.push_back(mk(32'h0, 8'h82, 2'd1, 1, xs(4'b1000, 1'b1)));
    vt.push_back(mk(32'h0, 8'h82, 2'd1, 4, xb(1'b0)));
    vt.push_back(mk(32'h0, 8'h82, 2'd1, 7, xb(1'b1)));
    vt.push_back(mk(32'h0, 8'h00, 2'd2, 0, xs(4'b0001, 1'b0)));
    vt.push_back(mk(32'h0, 8'h00, 2'd2, 1, xs(4'b0010, 1'b0)));
    vt.push_back(mk(32'h0, 8'h00, 2'd2, 3, xb(1'b0)));
    vt.push_back(mk(32'hFFFF_FFFF, 8'h04, 2'd3, 2, xb(1'b1)));
    vt.push_back(mk(32'hFFFF_FFFF, 8'h04, 2'd3, 0, xb(1'b0)));
    vt.push_back(mk(32'h0000_0050, 8'h00, 2'd0, 0, xn(4'h0, 1'b0)));
    vt.push_back(mk(32'h0000_0050, 8'h00, 2'd0, 1, xn(4'h5, 1'b0)));
    vt.push_back(mk(32'h0000_0050, 8'h00, 2'd0, 2, lz(1'b0)));
    vt.push_back(mk(32'h0000_0050, 8'h00, 2'd0, 7, lz(1'b0)));
    vt.push_back(mk(32'h0, 8'hFF, 2'd0, 0, xn(4'h0, 1'b1)));
    vt.push_back(mk(32'h0, 8'hFF, 2'd0, 3, lz(1'b1)));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", 32'(obs()), 32'(xb(1'b0)));
    check("rst_an_n", 32'(bus.an_n), 32'hFF);
    check("rst_frame", 32'(bus.frame), 32'd0);

    // idle scan with nothing loaded
    @(negedge clk);
    reset = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      step();
      ea = (j < 2) ? 8'hFF : ~(8'b1 << (((j - 2) / 4) % 8));
      check($sformatf("idle_scan_%0d", j),
            {22'd0, bus.an_n, bus.none, bus.frame},
            {22'd0, ea, 1'b1, 1'b0});
    end

    // decode table
    for (int i = 0; i < vt.size(); i++) begin
      if (i == 0 || vt[i].value != p.value ||
          vt[i].dots != p.dots || vt[i].mode != p.mode) begin
        do_load(vt[i].value, vt[i].dots, vt[i].mode);
        wait_frame($sformatf("vec%0d_frame", i));
        repeat (2) step();
      end
      p = vt[i];
      wait_digit(vt[i].digit, $sformatf("vec%0d_digit", i));
      check($sformatf("vec%0d_sel", i), 32'(obs()), 32'(vt[i].exp));
    end

    // two loads in one frame: only the last is shown
    do_load(32'hFFFF_FFFF, 8'h00, 2'd0);
    wait_frame("two_pre_frame");
    step();
    n0 = nframes;
    do_load(32'h1234_5678, 8'h00, 2'd0);
    step();
    do_load(32'h0000_00A5, 8'h00, 2'd0);
    wait_frame("two_frame");
    repeat (70) step();
    check("two_frame_count", 32'(nframes - n0), 32'd1);
    wait_digit(0, "two_d0");
    check("two_d0_sel", 32'(obs()), 32'(xn(4'h5, 1'b0)));
    wait_digit(1, "two_d1");
    check("two_d1_sel", 32'(obs()), 32'(xn(4'hA, 1'b0)));
    wait_digit(4, "two_d4");
    check("two_d4_sel", 32'(obs()), 32'(lz(1'b0)));

    // load in the wrap cycle goes straight to active
    do_load(32'h1111_1111, 8'h00, 2'd0);
    wait_frame("byp_pre_frame");
    repeat (31) @(posedge clk);
    @(negedge clk);
    bus.load = 1'b1; bus.value = 32'h0; bus.dots = 8'h00; bus.mode = 2'd1;
    @(posedge clk);
    #1;
    check("byp_frame", 32'(bus.frame), 32'd1);
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2) step();
    wait_digit(1, "byp_d1");
    check("byp_d1_sel", 32'(obs()), 32'(xs(4'b1000, 1'b0)));
    wait_digit(0, "byp_d0");
    check("byp_d0_sel", 32'(obs()), 32'(xs(4'b0100, 1'b0)));
    wait_digit(5, "byp_d5");
    check("byp_d5_sel", 32'(obs()), 32'(xb(1'b0)));

    // reset mid-frame with content pending, load ignored under reset
    do_load(32'h2222_2222, 8'hFF, 2'd0);
    step();
    @(negedge clk);
    reset = 1'b0;
    bus.load = 1'b1; bus.value = 32'h3333_3333; bus.dots = 8'hFF;
    bus.mode = 2'd0;
    @(posedge clk);
    #1;
    check("mid_rst_sel", 32'(obs()), 32'(xb(1'b0)));
    check("mid_rst_an_n", 32'(bus.an_n), 32'hFF);
    check("mid_rst_frame", 32'(bus.frame), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.load = 1'b0;
    n0  = nframes;
    bad = 0;
    for (int j = 0; j < 80; j++) begin
      step();
      if (obs() !== xb(1'b0)) bad++;
    end
    check("post_rst_blank", 32'(bad), 32'd0);
    check("post_rst_frames", 32'(nframes - n0), 32'd0);
    do_load(32'h0000_000C, 8'h00, 2'd0);
    wait_frame("post_rst_load");
    repeat (2) step();
    wait_digit(0, "post_rst_d0");
    check("post_rst_d0_sel", 32'(obs()), 32'(xn(4'hC, 1'b0)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
